// File: rtl/reg_file_2r1w_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared defaults and types for the little_proc register file.
//   RF_DATA_W    : default word width
//   RF_NUM_REGS  : default register count (power of two, at least 2)
//   RF_ADDR_W    : address width derived from RF_NUM_REGS
//   RF_ZERO_ADDR : the hardwired-zero register index
//   rf_addr_t    : address type at the default geometry
//   rf_word_t    : data word type at the default geometry
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W    = 8;
    localparam int RF_NUM_REGS  = 8;
    localparam int RF_ADDR_W    = $clog2(RF_NUM_REGS);
    localparam int RF_ZERO_ADDR = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_2r1w_en_reg.sv
// ----------------------------------------------------------------------------
// en_reg
// One storage word of the register file: a DATA_W-wide D register that only
// loads when en is high, and clears to zero on reset.
//   clk   : system clock, loads on posedge
//   reset : asynchronous, active-low reset
//   en    : load enable
//   d     : next value
//   q     : stored value
// ----------------------------------------------------------------------------
module en_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Hold the stored word unless a write targets this register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
// NUM_REGS x DATA_W register file with one write port and two independent
// registered read ports. Register 0 always reads as zero, and a read that
// collides with a same-cycle write to the same nonzero address returns the
// newly written data.
//   clk                 : system clock
//   reset               : asynchronous, active-low reset
//   wr_en/wr_addr/wr_data : write port
//   rdN_en/rdN_addr     : read request for port N (N = 0, 1)
//   rdN_data            : read result, one cycle after the request
//   rdN_valid           : high for exactly one cycle per accepted request
// ----------------------------------------------------------------------------
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] words [NUM_REGS];
    logic [DATA_W-1:0] rd0_next;
    logic [DATA_W-1:0] rd1_next;

    // Register 0 has no storage, so reads of it are zero by construction and
    // writes to it have nowhere to land.
    assign words[0] = '0;

    // One enable-gated storage word per nonzero address.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        en_reg #(
            .DATA_W(DATA_W)
        ) u_word (
            .clk  (clk),
            .reset(reset),
            .en   (wr_en && (wr_addr == ADDR_W'(i))),
            .d    (wr_data),
            .q    (words[i])
        );
    end

    // Port 0 read mux: forward the in-flight write so the reader sees the new
    // value; address 0 is excluded so it keeps reading zero.
    always_comb begin
        rd0_next = words[rd0_addr];
        if (wr_en && (wr_addr == rd0_addr) && (rd0_addr != ZERO_ADDR)) begin
            rd0_next = wr_data;
        end
    end

    // Port 1 read mux, same forwarding rule as port 0.
    always_comb begin
        rd1_next = words[rd1_addr];
        if (wr_en && (wr_addr == rd1_addr) && (rd1_addr != ZERO_ADDR)) begin
            rd1_next = wr_data;
        end
    end

    // Port 0 output register: valid follows the request each cycle, while data
    // only updates on a request so the last result stays visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd0_data  <= '0;
            rd0_valid <= 1'b0;
        end else begin
            rd0_valid <= rd0_en;
            if (rd0_en) begin
                rd0_data <= rd0_next;
            end
        end
    end

    // Port 1 output register, same behaviour as port 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_data  <= '0;
            rd1_valid <= 1'b0;
        end else begin
            rd1_valid <= rd1_en;
            if (rd1_en) begin
                rd1_data <= rd1_next;
            end
        end
    end

endmodule
